// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver with per-digit dp/blank and dead time.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module sev_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_load,
  input  logic [4*NUM_DIGITS-1:0]   i_value,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic [NUM_DIGITS-1:0]     i_blank,
  output logic [7:0]                o_sev_seg,
  output logic [NUM_DIGITS-1:0]     o_an,
  output logic                      o_frame
);

  localparam int CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ON_CYCLES = CLK_DIV - DEAD_CYCLES;

  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dp_q, blank_q, lz_mask;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;
  logic                    cnt_last, idx_last, on_phase;
  logic [3:0]              nib;
  logic                    dp_sel, blank_sel, supp_sel;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit; zeros before the first non-zero nibble go dark.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (val_q[4*i +: 4] != 4'h0) seen = 1'b1;
      lz_mask[i] = ~seen;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    cnt_last = (cnt_q == CW'(CLK_DIV - 1));
    idx_last = (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_last) idx_d = idx_last ? '0 : idx_q + 1'b1;
    frame_d  = cnt_last & idx_last;
    // Extra bit so ON_CYCLES == CLK_DIV (no dead time) still compares correctly.
    on_phase = ({1'b0, cnt_q} < (CW+1)'(ON_CYCLES));

    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    supp_sel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = val_q[4*i +: 4];
        dp_sel    = dp_q[i];
        blank_sel = blank_q[i];
        supp_sel  = lz_mask[i];
      end
    end

    seg_d = 8'hFF;
    an_d  = '1;
    if (on_phase) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!blank_sel) seg_d = {~dp_sel, supp_sel ? 7'h7F : hex7(nib)};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      val_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      if (i_load) begin
        val_q   <= i_value;
        dp_q    <= i_dp;
        blank_q <= i_blank;
      end
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign o_sev_seg = seg_q;
  assign o_an      = an_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Directed bench for sev_seg_scan_driver with NUM_DIGITS=4, CLK_DIV=4, DEAD_CYCLES=1.
// Expected per-digit segment bytes are hand-computed; define LEADING_ZERO_BLANK_EN for the suppression variant.
module tb_sev_seg_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int DC = 1;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [7:0]  exp_seg [4];
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp = '0;
  logic [3:0]    blank = '0;
  logic [7:0]    sev_seg;
  logic [3:0]    an;
  logic          frame;

  int            checks = 0;
  int            errors = 0;
  int            n = 0;
  bit            chk_en = 1'b0;
  logic [7:0]    cur_exp [4];
  vec_t          vecs [6];

  sev_seg_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .DEAD_CYCLES(DC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value(value), .i_dp(dp),
    .i_blank(blank), .o_sev_seg(sev_seg), .o_an(an), .o_frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %02h expected %02h", name, n, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, sev_seg, 8'hFF);
    chk({tag, "_an"}, {4'h0, an}, 8'h0F);
    chk({tag, "_frame"}, {7'h0, frame}, 8'h00);
  endtask

  // Edge n (n>=1 after reset release) shows slot position cnt=(n-1)%4, digit=((n-1)/4)%4.
  task automatic check_outputs();
    int c, d;
    logic [3:0] ea;
    logic [7:0] es;
    c  = (n - 1) % CD;
    d  = ((n - 1) / CD) % ND;
    ea = 4'hF;
    es = 8'hFF;
    if (c < CD - DC) begin
      ea = ~(4'b0001 << d);
      es = cur_exp[d];
    end
    chk("seg", sev_seg, es);
    chk("an", {4'h0, an}, {4'h0, ea});
    chk("frame", {7'h0, frame}, {7'h0, (n % (CD * ND)) == 0});
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
    if (chk_en) check_outputs();
  endtask

  task automatic align_frame();
    chk_en = 1'b0;
    for (int i = 0; i < CD * ND && (n % (CD * ND)) != 0; i++) tick();
  endtask

  task automatic run_frames(input int frames);
    chk_en = 1'b1;
    for (int i = 0; i < frames * CD * ND; i++) tick();
    chk_en = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    value = v.value;
    dp    = v.dp;
    blank = v.blank;
    load  = 1'b1;
    chk_en = 1'b0;
    tick();
    load = 1'b0;
    for (int d = 0; d < 4; d++) cur_exp[d] = v.exp_seg[d];
  endtask

  task automatic set_zero_exp();
`ifdef LEADING_ZERO_BLANK_EN
    cur_exp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
`else
    cur_exp = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
  endtask

  initial begin
    vecs[0] = '{16'h1A2F, 4'b0100, 4'b0000, '{8'h8E, 8'hA4, 8'h08, 8'hF9}};
    vecs[1] = '{16'h1111, 4'b0000, 4'b0010, '{8'hF9, 8'hFF, 8'hF9, 8'hF9}};
    vecs[2] = '{16'h8D30, 4'b0001, 4'b0000, '{8'h40, 8'hB0, 8'hA1, 8'h80}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[3] = '{16'h0050, 4'b0000, 4'b0000, '{8'hC0, 8'h92, 8'hFF, 8'hFF}};
    vecs[4] = '{16'h0000, 4'b0000, 4'b0000, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};
    vecs[5] = '{16'h0000, 4'b1000, 4'b0100, '{8'hC0, 8'hFF, 8'hFF, 8'h7F}};
`else
    vecs[3] = '{16'h0050, 4'b0000, 4'b0000, '{8'hC0, 8'h92, 8'hC0, 8'hC0}};
    vecs[4] = '{16'h0000, 4'b0000, 4'b0000, '{8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[5] = '{16'h0000, 4'b1000, 4'b0100, '{8'hC0, 8'hC0, 8'hFF, 8'h40}};
`endif

    // Reset held: outputs at reset values even across clock edges.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    value = 16'hFFFF;
    rst_n = 1'b1;
    n = 0;
    set_zero_exp();
    run_frames(1);

    // Table-driven vectors: each loaded, then two full frames checked cycle by cycle.
    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v]);
      align_frame();
      run_frames(2);
    end

    // Live inputs change without a load: display must hold the last snapshot.
    load_vec(vecs[0]);
    align_frame();
    value = 16'h8888;
    dp    = 4'b1111;
    blank = 4'b1111;
    run_frames(2);
    load_vec(vecs[2]);
    align_frame();
    run_frames(1);

    // Load mid-slot: the digit being shown switches on the very next edge.
    for (int i = 0; i < CD * ND && (n % (CD * ND)) != 5; i++) tick();
    value = vecs[0].value;
    dp    = vecs[0].dp;
    blank = vecs[0].blank;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    chk_en = 1'b1;
    for (int d = 0; d < 4; d++) cur_exp[d] = vecs[0].exp_seg[d];
    tick();
    chk_en = 1'b0;

    // Asynchronous reset in the middle of digit 2's slot.
    for (int i = 0; i < CD * ND && (n % (CD * ND)) != 10; i++) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst_n = 1'b1;
    n = 0;
    set_zero_exp();
    run_frames(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
